// File: rtl/banked_memory_ctrl.sv
// Parametrised single-port synchronous RAM with per-byte write enables,
// registered reads, optional write-readback and an automatic zero-clear after reset.
module banked_memory_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int WRITE_READBACK = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      writeEnable,
  input  logic [DATA_WIDTH/8-1:0]   byteEnable,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     writeData,
  output logic [DATA_WIDTH-1:0]     readData,
  output logic                      readValid,
  output logic                      ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clearAddr;
  logic [DATA_WIDTH-1:0]   r_readData;
  logic                    r_readValid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_accept = enable && r_ready;
  assign w_old    = r_mem[address];

  // Masked lanes take the new byte, the rest keep the stored byte.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < BYTES; i++) begin
      if (byteEnable[i]) w_merged[8*i +: 8] = writeData[8*i +: 8];
    end
  end

  // Storage has no reset: the reset edge itself leaves contents untouched.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clearAddr] <= '0;
      end else if (w_accept && writeEnable) begin
        r_mem[address] <= w_merged;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_clearAddr <= '0;
      r_readData  <= '0;
      r_readValid <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_readValid <= 1'b0;
          r_clearAddr <= r_clearAddr + 1'b1;
          if (r_clearAddr == '1) begin
            r_ready <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_readValid <= 1'b0;
          if (w_accept) begin
            if (!writeEnable) begin
              r_readData  <= w_old;
              r_readValid <= 1'b1;
            end else if (WRITE_READBACK != 0) begin
              r_readData  <= w_merged;
              r_readValid <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign readData  = r_readData;
  assign readValid = r_readValid;
  assign ready     = r_ready;

endmodule

// File: doc/banked_memory_ctrl.md
# banked_memory_ctrl

Parametrised single-port synchronous RAM. It supersedes the fixed 16-bit memory in the processor datapath. Over the old block it adds configurable data width and depth, per-byte write enables, a registered read with a `readValid` strobe, and an optional write-readback mode. After every reset it automatically zero-clears its contents, and the processor must wait for `ready` before issuing requests.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width in bits; must be a multiple of 8. `BYTES = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 8, address width in bits. `DEPTH = 2**ADDR_WIDTH` words.
- `WRITE_READBACK`, 0, when 1 every accepted write also returns the merged stored word on `readData` with `readValid`.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  request strobe, sampled each rising edge.
- `writeEnable`  in  1  1 = write request, 0 = read request; valid with `enable`.
- `byteEnable`  in  BYTES  per-lane write mask; bit i covers `writeData[8i+7:8i]`.
- `address`  in  ADDR_WIDTH  word address.
- `writeData`  in  DATA_WIDTH  write word.
- `readData`  out  DATA_WIDTH  registered read word; holds its value between reads.
- `readValid`  out  1  one-cycle pulse when `readData` is updated.
- `ready`  out  1  1 = requests are accepted; 0 = clearing or in reset.

## Operation
- States: CLEAR and RUN.
- **Reset.** On any edge with `reset`=1 the block enters CLEAR and sets `clearAddr`=0, `readData`=0, `readValid`=0 and `ready`=0.
  - Holding `reset` keeps the block there.
  - Reset mid-clear or mid-read aborts the operation and restarts the clear from address 0.
  - Memory contents are not altered by the reset edge itself.
- **CLEAR.**
  - Each edge with `reset`=0 writes 0 to `mem[clearAddr]` and increments `clearAddr`.
  - The edge that clears address DEPTH-1 also sets `ready`=1 and moves to RUN.
  - `enable` is ignored while in CLEAR. Requests are silently dropped: no write, no `readValid`.
- **RUN, accepted request.** A request is accepted on an edge with `enable`=1 and `ready`=1.
  - **Read** (`writeEnable`=0): `readData` <= `mem[address]` and `readValid` <= 1.
  - **Write** (`writeEnable`=1): each lane i with `byteEnable[i]`=1 gets `mem[address][8i+7:8i]` <= `writeData[8i+7:8i]`. Lanes with the mask bit clear keep their value.
    - A write with `byteEnable`=0 is accepted but changes nothing.
    - If `WRITE_READBACK`=1, `readData` <= the merged word (new lanes plus old lanes) and `readValid` <= 1.
    - If `WRITE_READBACK`=0, `readData` holds its value and `readValid` <= 0.
- **RUN, idle edge** (`enable`=0): `readValid` <= 0; `readData` holds.
- **Address range.** Every address is in range because DEPTH = 2**ADDR_WIDTH; no wrap logic is needed beyond the counter.
- **Storage.** Memory is a synchronous array with no initial-file load.

## Timing
- Read latency is 1 cycle. Data and `readValid` appear after the accepting edge and are valid for one cycle.
- Back-to-back requests are supported every cycle with no bubbles.
- Read-after-write to the same address on the next cycle returns the new data.
- Clear time is exactly DEPTH edges: `ready` is 1 after the DEPTH-th rising edge with `reset`=0.
- Reset values: `readData`=0, `readValid`=0, `ready`=0.

## Test plan
Bench configuration: `DATA_WIDTH`=16, `ADDR_WIDTH`=4, `WRITE_READBACK`=0 unless stated otherwise.
- **Reset and clear.** Assert `reset` for 2 edges, then release. `ready` must be 0 for edges 1..15 and 1 after edge 16. Then read 0xF: `readData`=0x0000 with a single `readValid` pulse one cycle later.
- **Full-word write/read.** Write 0xFA2D to 0xF with `byteEnable`=2'b11, then read 0xF on the next cycle. Required: `readData`=0xFA2D, `readValid`=1 for one cycle, and no `readValid` for the write.
- **Byte lanes.** Start with 0xF holding 0xFA2D.
  - Write 0x1199 with mask 2'b01, then read: 0xFA99.
  - Write 0x2200 with mask 2'b10, then read: 0x2299.
  - Write with mask 2'b00, then read: still 0x2299.
- **Drop during clear.** Issue a write of 0x9999 to 0x3 while `ready`=0. After `ready` rises, read 0x3: must be 0x0000.
- **Reset mid-clear.** Assert `reset` on the edge after clear edge 5. `ready` stays 0 and must rise only after 16 further edges with `reset`=0. Issue a read during the reset: no `readValid`.
- **Write-readback.** With `WRITE_READBACK`=1, 0x4 holds 0x0000. Write 0x2231 with mask 2'b10: `readData`=0x2200 and `readValid`=1 on the next cycle.
